dmem_line_responder: RTL

Line-granular data memory that answers the data cache's miss and write-back requests on the 256-bit memory-side interface. It accepts one request at a time: a 256-bit line read (refill) or a line write (eviction). Each request completes after a fixed, configurable latency and is signalled with a one-cycle acknowledge. It sits between the dcache memory port and the testbench/top level and stands in for off-chip DRAM.

---
 rtl/dmem_line_responder_if.sv | 15 +
 rtl/dmem_line_responder.sv | 98 +++++++++
 2 files changed

// File: rtl/dmem_line_responder_if.sv
// Memory-side line bus between the dcache and the line responder.
interface dmem_line_responder_if;
  logic         enable_i;
  logic         write_i;
  logic [31:0]  addr_i;
  logic [255:0] data_i;
  logic [255:0] data_o;
  logic         ack_o;
  logic         err_o;

  modport master (output enable_i, write_i, addr_i, data_i,
                  input  data_o, ack_o, err_o);
  modport slave  (input  enable_i, write_i, addr_i, data_i,
                  output data_o, ack_o, err_o);
endinterface

// File: rtl/dmem_line_responder.sv
// Fixed-latency 256-bit line memory standing in for DRAM behind the dcache.
// Define DMEM_PROTO_CHECK_EN to compile in the sticky protocol checker on err_o.
module dmem_line_responder #(
  parameter int unsigned LATENCY = 10,
  parameter int unsigned ADDR_W  = 9
) (
  input logic                  clk_i,
  input logic                  rst_i,
  dmem_line_responder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] idx;
    logic [255:0]      data;
  } req_t;

  localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

  state_t            state;
  logic [7:0]        cnt;
  req_t              req;
  logic              ack_q;
  logic [255:0]      data_q;
  logic [ADDR_W-1:0] addr_idx;
  logic              mem_we;
  logic              unused_bits;

  // No reset on the array: contents survive reset and are preloaded externally.
  logic [255:0] mem [2**ADDR_W];

  assign addr_idx    = bus.addr_i[ADDR_W+4:5];
  assign unused_bits = ^{bus.addr_i[4:0], bus.addr_i[31:ADDR_W+5]};
  assign mem_we      = !rst_i && state == BUSY && cnt == '0 && req.write;

  always_ff @(posedge clk_i) begin
    if (mem_we) mem[req.idx] <= req.data;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      cnt    <= '0;
      req    <= '0;
      ack_q  <= 1'b0;
      data_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          ack_q <= 1'b0;
          if (bus.enable_i) begin
            req   <= '{write: bus.write_i, idx: addr_idx, data: bus.data_i};
            cnt   <= CNT_INIT;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - 8'd1;
          end else begin
            if (!req.write) data_q <= mem[req.idx];
            ack_q <= 1'b1;
            state <= ACK;
          end
        end
        ACK: begin
          ack_q <= 1'b0;
          state <= IDLE;
        end
        default: begin
          ack_q <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.ack_o  = ack_q;
  assign bus.data_o = data_q;

`ifdef DMEM_PROTO_CHECK_EN
  logic err_q;

  // Observes only; a flagged request still runs to completion.
  always_ff @(posedge clk_i) begin
    if (rst_i)
      err_q <= 1'b0;
    else if (state == BUSY &&
             (!bus.enable_i || addr_idx != req.idx || bus.write_i != req.write))
      err_q <= 1'b1;
  end

  assign bus.err_o = err_q;
`else
  assign bus.err_o = 1'b0;
`endif
endmodule
